// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard inputs from the datapath and the
// write-enable/flush controls that go back to the PC and stage registers.
// master = datapath side, slave = pipeline_hazard_ctrl.
// Optional HAZARD_PERF_EN adds the stall/flush performance counters.
interface pipeline_hazard_ctrl_if;
  // hazard inputs
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       id_needs_md;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       br_taken;
  logic       md_start;
  logic       md_is_div;
  // pipeline controls
  logic       pc_wr;
  logic       ifid_wr;
  logic       ifid_flush;
  logic       idex_wr;
  logic       idex_flush;
  logic       exmem_wr;
  logic       memwb_wr;
  logic       md_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  modport master (
`ifdef HAZARD_PERF_EN
    input  perf_stall_cnt,
    input  perf_flush_cnt,
`endif
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_needs_md,
    output ex_mem_read, ex_rd, br_taken, md_start, md_is_div,
    input  pc_wr, ifid_wr, ifid_flush, idex_wr, idex_flush,
    input  exmem_wr, memwb_wr, md_busy
  );

  modport slave (
`ifdef HAZARD_PERF_EN
    output perf_stall_cnt,
    output perf_flush_cnt,
`endif
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_needs_md,
    input  ex_mem_read, ex_rd, br_taken, md_start, md_is_div,
    output pc_wr, ifid_wr, ifid_flush, idex_wr, idex_flush,
    output exmem_wr, memwb_wr, md_busy
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Handles load-use hazards, taken branches/jumps and the multi-cycle
// mult/div unit. Control outputs are combinational from state + inputs;
// md_busy is registered.
// Optional feature macro: HAZARD_PERF_EN (saturating stall/flush counters).
module pipeline_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic clk,
  input  logic rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_RUN     = 2'd1,
    ST_MD_BUSY = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] MUL_LOAD = CNT_WIDTH'(MUL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DIV_LOAD = CNT_WIDTH'(DIV_CYCLES - 1);

  state_t               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 md_busy_q;

  logic load_use;
  logic md_hazard;
  logic stall;
  logic pc_wr_d, ifid_wr_d, ifid_flush_d, idex_wr_d, idex_flush_d;
  logic exmem_wr_d, memwb_wr_d;

  // Hazard detection and per-stage control decode (branch squash beats stall)
  always_comb begin
    load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
               ((hz.id_uses_rs && (hz.id_rs == hz.ex_rd)) ||
                (hz.id_uses_rt && (hz.id_rt == hz.ex_rd)));
    md_hazard = hz.id_needs_md && (md_busy_q || hz.md_start);
    stall     = load_use || md_hazard;

    pc_wr_d      = 1'b1;
    ifid_wr_d    = 1'b1;
    ifid_flush_d = 1'b0;
    idex_wr_d    = 1'b1;
    idex_flush_d = 1'b0;
    exmem_wr_d   = 1'b1;
    memwb_wr_d   = 1'b1;

    if (state_q == ST_RESET) begin
      pc_wr_d      = 1'b0;
      ifid_wr_d    = 1'b0;
      ifid_flush_d = 1'b1;
      idex_wr_d    = 1'b0;
      idex_flush_d = 1'b1;
      exmem_wr_d   = 1'b0;
      memwb_wr_d   = 1'b0;
    end else if (hz.br_taken) begin
      // fetch the target, squash the wrong-path IF and ID instructions
      ifid_flush_d = 1'b1;
      idex_flush_d = 1'b1;
    end else if (stall) begin
      // hold PC and IF/ID, bubble into EX, let older instructions drain
      pc_wr_d      = 1'b0;
      ifid_wr_d    = 1'b0;
      idex_flush_d = 1'b1;
    end
  end

  // Sequencer FSM: reset hold, run, and mult/div busy countdown
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      md_busy_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RESET: begin
          state_q   <= ST_RUN;
          md_busy_q <= 1'b0;
        end
        ST_RUN: begin
          if (hz.md_start) begin
            cnt_q     <= hz.md_is_div ? DIV_LOAD : MUL_LOAD;
            state_q   <= ST_MD_BUSY;
            md_busy_q <= 1'b1;
          end
        end
        ST_MD_BUSY: begin
          // a second md_start here cannot be legal: the issuer is stalled
          if (cnt_q == '0) begin
            state_q   <= ST_RUN;
            md_busy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q   <= ST_RESET;
          cnt_q     <= '0;
          md_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign hz.pc_wr      = pc_wr_d;
  assign hz.ifid_wr    = ifid_wr_d;
  assign hz.ifid_flush = ifid_flush_d;
  assign hz.idex_wr    = idex_wr_d;
  assign hz.idex_flush = idex_flush_d;
  assign hz.exmem_wr   = exmem_wr_d;
  assign hz.memwb_wr   = memwb_wr_d;
  assign hz.md_busy    = md_busy_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  // Saturating counters of stall cycles and branch-flush cycles outside reset
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else if (state_q != ST_RESET) begin
      if (stall && !hz.br_taken && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
      if (hz.br_taken && (perf_flush_q != 32'hFFFF_FFFF))
        perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign hz.perf_stall_cnt = perf_stall_q;
  assign hz.perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (MUL_CYCLES=4, DIV_CYCLES=32).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_pipeline_hazard_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(
    .MUL_CYCLES(4),
    .DIV_CYCLES(32),
    .CNT_WIDTH (6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_wr, ifid_wr, ifid_flush, idex_wr, idex_flush, exmem_wr, memwb_wr}
  wire [6:0] ctl = {hz.pc_wr, hz.ifid_wr, hz.ifid_flush, hz.idex_wr,
                    hz.idex_flush, hz.exmem_wr, hz.memwb_wr};

  localparam logic [6:0] CTL_RESET = 7'b0010100;
  localparam logic [6:0] CTL_RUN   = 7'b1101011;
  localparam logic [6:0] CTL_STALL = 7'b0001111;
  localparam logic [6:0] CTL_FLUSH = 7'b1111111;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      $display("check %-14s obs=%0h exp=%0h ok", tag, obs, exp);
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    hz.id_rs = 5'd0; hz.id_rt = 5'd0;
    hz.id_uses_rs = 1'b0; hz.id_uses_rt = 1'b0; hz.id_needs_md = 1'b0;
    hz.ex_mem_read = 1'b0; hz.ex_rd = 5'd0; hz.br_taken = 1'b0;
    hz.md_start = 1'b0; hz.md_is_div = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_inputs();

    // 1: reset held 3 cycles, then one RESET cycle after release, then RUN
    repeat (3) @(posedge clk);
    step();
    chk("rst_hold_ctl", {25'd0, ctl}, {25'd0, CTL_RESET});
    chk("rst_hold_busy", {31'd0, hz.md_busy}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_post_ctl", {25'd0, ctl}, {25'd0, CTL_RESET});
    step();
    chk("run_idle_ctl", {25'd0, ctl}, {25'd0, CTL_RUN});

    // 2: load-use on rs stalls in the same cycle; ex_rd=0 never stalls
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd8; hz.id_rs = 5'd8; hz.id_uses_rs = 1'b1;
    #1;
    chk("lu_rs_stall", {25'd0, ctl}, {25'd0, CTL_STALL});
    hz.ex_rd = 5'd0; hz.id_rs = 5'd0;
    #1;
    chk("lu_rd0_none", {25'd0, ctl}, {25'd0, CTL_RUN});
    hz.ex_rd = 5'd9; hz.id_rs = 5'd9; hz.id_uses_rs = 1'b0;
    #1;
    chk("lu_rs_unused", {25'd0, ctl}, {25'd0, CTL_RUN});
    hz.id_rt = 5'd9; hz.id_uses_rt = 1'b1;
    #1;
    chk("lu_rt_stall", {25'd0, ctl}, {25'd0, CTL_STALL});
    hz.ex_mem_read = 1'b0;
    #1;
    chk("lu_not_load", {25'd0, ctl}, {25'd0, CTL_RUN});

    // 3: taken branch overrides a load-use stall
    step();
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd8; hz.id_rs = 5'd8; hz.id_uses_rs = 1'b1;
    hz.br_taken = 1'b1;
    #1;
    chk("br_over_stall", {25'd0, ctl}, {25'd0, CTL_FLUSH});
    step();
    idle_inputs();
    #1;
    chk("br_after_idle", {25'd0, ctl}, {25'd0, CTL_RUN});

    // 4: mult issue with a dependent mfhi in ID; branch lands in busy cycle 2
    step();
    hz.md_start = 1'b1; hz.md_is_div = 1'b0; hz.id_needs_md = 1'b1;
    #1;
    chk("mul_issue_stall", {25'd0, ctl}, {25'd0, CTL_STALL});
    chk("mul_issue_busy", {31'd0, hz.md_busy}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      hz.md_start = 1'b0;
      hz.br_taken = (k == 2);
      #1;
      chk($sformatf("mul_busy_%0d", k), {31'd0, hz.md_busy}, 32'd1);
      chk($sformatf("mul_ctl_%0d", k), {25'd0, ctl},
          {25'd0, (k == 2) ? CTL_FLUSH : CTL_STALL});
    end
    step();
    hz.br_taken = 1'b0;
    #1;
    chk("mul_done_busy", {31'd0, hz.md_busy}, 32'd0);
    chk("mul_done_pcwr", {31'd0, hz.pc_wr}, 32'd1);
    chk("mul_done_ctl", {25'd0, ctl}, {25'd0, CTL_RUN});

    // 5: div aborted by reset at busy cycle 10, then clean restart
    step();
    idle_inputs();
    hz.md_start = 1'b1; hz.md_is_div = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      hz.md_start = 1'b0;
      #1;
      if (k == 1 || k == 5 || k == 10)
        chk($sformatf("div_busy_%0d", k), {31'd0, hz.md_busy}, 32'd1);
    end
    rst = 1'b1;
    step();
    chk("div_rst_busy", {31'd0, hz.md_busy}, 32'd0);
    chk("div_rst_ctl", {25'd0, ctl}, {25'd0, CTL_RESET});
    rst = 1'b0;
    hz.id_needs_md = 1'b1;
    #1;
    chk("div_rel_ctl", {25'd0, ctl}, {25'd0, CTL_RESET});
    step();
    chk("div_run_ctl", {25'd0, ctl}, {25'd0, CTL_RUN});
    chk("div_run_busy", {31'd0, hz.md_busy}, 32'd0);
    step();
    chk("div_run_busy2", {31'd0, hz.md_busy}, 32'd0);
    // counter restarted cleanly: a fresh mult still runs exactly 4 cycles
    hz.id_needs_md = 1'b0; hz.md_start = 1'b1; hz.md_is_div = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      hz.md_start = 1'b0;
      #1;
      chk($sformatf("mul2_busy_%0d", k), {31'd0, hz.md_busy}, 32'd1);
    end
    step();
    chk("mul2_done", {31'd0, hz.md_busy}, 32'd0);

`ifdef HAZARD_PERF_EN
    // 6: 3 load-use stall cycles + 2 taken-branch cycles, then reset clears
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    idle_inputs();
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd4; hz.id_rs = 5'd4; hz.id_uses_rs = 1'b1;
    repeat (3) step();
    idle_inputs();
    hz.br_taken = 1'b1;
    repeat (2) step();
    idle_inputs();
    step();
    chk("perf_stall", hz.perf_stall_cnt, 32'd3);
    chk("perf_flush", hz.perf_flush_cnt, 32'd2);
    rst = 1'b1;
    step();
    chk("perf_stall_rst", hz.perf_stall_cnt, 32'd0);
    chk("perf_flush_rst", hz.perf_flush_cnt, 32'd0);
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
